// File: rtl/bnn_pkg.sv
// Shared constants and helpers for the binary-weight CNN activation stages.
package bnn_pkg;

    localparam int ACT_W  = 8;
    localparam int ACC_W  = 32;
    localparam int L1_DIM = 24;
    localparam int L2_DIM = 8;
    localparam int KSIZE  = 5;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_RUN,
        FR_FINISHED,
        FR_ABORTED
    } frame_state_e;

    function automatic logic [ACT_W-1:0] sat_u8(input logic signed [ACC_W-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > 255) begin
            return '1;
        end else begin
            return v[ACT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module pool_linebuf #(
    parameter int DEPTH = 12,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conv_pool_quant.sv
// 2x2 stride-2 max pooling of the conv stream, followed by shift and u8 clamp.
module conv_pool_quant
    import bnn_pkg::*;
#(
    parameter int W0    = L1_DIM,
    parameter int W1    = L2_DIM,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    state,
    input  logic signed [ACC_W-1:0] din,
    input  logic                    ivalid,
    input  logic                    idone,
    output logic [ACT_W-1:0]        dout,
    output logic                    ovalid,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(W0);
    localparam int AW = CW - 1;

    frame_state_e fs_q, fs_d;

    logic                    layer_q, layer_d;
    logic [CW-1:0]           col_q, col_d, row_q, row_d, wmax;
    logic signed [ACC_W-1:0] hold_q, hold_d, hmax_q, hmax_d;
    logic                    hv_q, hv_d, hodd_q, hodd_d, hlast_q, hlast_d;
    logic [AW-1:0]           hidx_q, hidx_d;
    logic [ACT_W-1:0]        dout_q, dout_d;
    logic                    ovalid_q, ovalid_d, last_out_q, last_out_d;
    logic                    done_q, done_d, err_q, err_d;

    logic                    run_ok, accept, pix_last, frame_done_now, abort;
    logic                    rd_en, we;
    logic [AW-1:0]           rd_addr;
    logic signed [ACC_W-1:0] lb_rdata, p, p_shr;

    assign wmax           = layer_q ? CW'(W1 - 1) : CW'(W0 - 1);
    assign accept         = start && ivalid && run_ok;
    assign pix_last       = (col_q == wmax) && (row_q == wmax);
    // A pixel completing the frame in the same cycle as idone counts as completed.
    assign frame_done_now = (fs_q == FR_FINISHED) || (accept && pix_last);
    assign abort          = start && idone && !frame_done_now && (fs_q != FR_ABORTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_q <= FR_IDLE;
        end else begin
            fs_q <= fs_d;
        end
    end

    always_comb begin
        fs_d = fs_q;
        if (!start) begin
            fs_d = FR_IDLE;
        end else begin
            unique case (fs_q)
                FR_IDLE, FR_RUN: begin
                    if (accept && pix_last) begin
                        fs_d = FR_FINISHED;
                    end else if (abort) begin
                        fs_d = FR_ABORTED;
                    end else begin
                        fs_d = FR_RUN;
                    end
                end
                default: fs_d = fs_q;
            endcase
        end
    end

    always_comb begin
        run_ok = (fs_q == FR_IDLE) || (fs_q == FR_RUN);
    end

    always_comb begin
        layer_d = start ? layer_q : state;
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        hv_d    = 1'b0;
        hmax_d  = hmax_q;
        hidx_d  = hidx_q;
        hodd_d  = hodd_q;
        hlast_d = hlast_q;
        rd_en   = 1'b0;
        rd_addr = col_q[CW-1:1];

        if (!start || abort) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == wmax) begin
                col_d = '0;
                row_d = (row_q == wmax) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Horizontal pair; the line buffer read is launched now so it lands with hmax_q.
        if (accept) begin
            if (!col_q[0]) begin
                hold_d = din;
            end else begin
                hv_d    = !abort;
                hmax_d  = (din > hold_q) ? din : hold_q;
                hidx_d  = col_q[CW-1:1];
                hodd_d  = row_q[0];
                hlast_d = pix_last;
                rd_en   = row_q[0];
            end
        end

        we         = hv_q && !hodd_q;
        p          = (hmax_q > lb_rdata) ? hmax_q : lb_rdata;
        p_shr      = p >>> SHIFT;
        ovalid_d   = hv_q && hodd_q && start && !abort;
        dout_d     = ovalid_d ? sat_u8(p_shr) : dout_q;
        last_out_d = ovalid_d && hlast_q;
        done_d     = start && (last_out_q || abort);
        err_d      = err_q || abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            hv_q       <= 1'b0;
            hmax_q     <= '0;
            hidx_q     <= '0;
            hodd_q     <= 1'b0;
            hlast_q    <= 1'b0;
            dout_q     <= '0;
            ovalid_q   <= 1'b0;
            last_out_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            layer_q    <= layer_d;
            col_q      <= col_d;
            row_q      <= row_d;
            hold_q     <= hold_d;
            hv_q       <= hv_d;
            hmax_q     <= hmax_d;
            hidx_q     <= hidx_d;
            hodd_q     <= hodd_d;
            hlast_q    <= hlast_d;
            dout_q     <= dout_d;
            ovalid_q   <= ovalid_d;
            last_out_q <= last_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    pool_linebuf #(
        .DEPTH (W0 / 2),
        .AW    (AW),
        .DW    (ACC_W)
    ) u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr (hidx_q),
        .wdata (hmax_q),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (lb_rdata)
    );

    assign dout   = dout_q;
    assign ovalid = ovalid_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_conv_pool_quant.sv
// Bench for conv_pool_quant: two instances (SHIFT=0 and SHIFT=2) against a frame-level pooling model.
module tb_conv_pool_quant;

    logic               clk = 1'b0;
    logic               rst, start, state, ivalid, idone;
    logic signed [31:0] din;
    logic [7:0]         dout0, dout2;
    logic               ovalid0, ovalid2, done0, done2, err0, err2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int img [24][24];
    int q_v0[$], q_c0[$], q_v2[$], q_c2[$];
    int exp_done = -1;
    int done_seen0 = 0;
    int done_seen2 = 0;

    conv_pool_quant #(.W0(24), .W1(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .state(state), .din(din),
        .ivalid(ivalid), .idone(idone), .dout(dout0), .ovalid(ovalid0),
        .done(done0), .err(err0)
    );

    conv_pool_quant #(.W0(24), .W1(8), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .state(state), .din(din),
        .ivalid(ivalid), .idone(idone), .dout(dout2), .ovalid(ovalid2),
        .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: 2x2 signed max, arithmetic shift, clamp to 0..255.
    function automatic int pool_ref(input int a, input int b, input int c, input int d, input int sh);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        m = m >>> sh;
        if (m < 0) return 0;
        if (m > 255) return 255;
        return m;
    endfunction

    always @(negedge clk) begin : monitor
        int v, c;
        if (!rst) begin
            if (ovalid0) begin
                if (q_v0.size() == 0) begin
                    check_eq("ovalid0_unexpected", ovalid0, 0);
                end else begin
                    v = q_v0.pop_front();
                    c = q_c0.pop_front();
                    check_eq("dout0", dout0, v);
                    check_eq("latency0", cyc, c);
                end
            end
            if (ovalid2) begin
                if (q_v2.size() == 0) begin
                    check_eq("ovalid2_unexpected", ovalid2, 0);
                end else begin
                    v = q_v2.pop_front();
                    c = q_c2.pop_front();
                    check_eq("dout2", dout2, v);
                    check_eq("latency2", cyc, c);
                end
            end
            if (done0) begin
                done_seen0++;
                check_eq("done0_cycle", cyc, exp_done);
            end
            if (done2) begin
                done_seen2++;
                check_eq("done2_cycle", cyc, exp_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q_v0.delete();
        q_c0.delete();
        q_v2.delete();
        q_c2.delete();
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                img[r][c] = r * 24 + c;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                img[r][c] = v;
    endtask

    task automatic fill_rand(input int mode);
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++) begin
                if (mode == 0)
                    img[r][c] = int'($urandom_range(0, 2400)) - 1200;
                else if ($urandom_range(0, 3) == 0)
                    img[r][c] = int'($urandom);
                else
                    img[r][c] = int'($urandom_range(0, 40)) - 30;
            end
    endtask

    // gapmode: 0 back-to-back, 1 row-shaped gaps (4 idle per row), 2 random gaps.
    task automatic run_frame(input bit layer, input int gapmode, input int abort_at, input int rst_at);
        int w, idx, exp_dn;
        bit aborted;
        w       = layer ? 8 : 24;
        idx     = 0;
        aborted = 1'b0;
        exp_dn  = 1;
        start   = 1'b0;
        state   = layer;
        ivalid  = 1'b0;
        idone   = 1'b0;
        tick();
        tick();
        done_seen0 = 0;
        done_seen2 = 0;
        exp_done   = -1;
        start      = 1'b1;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx == rst_at) begin
                    ivalid = 1'b0;
                    rst    = 1'b1;
                    tick();
                    check_eq("rst_dout0", dout0, 0);
                    check_eq("rst_dout2", dout2, 0);
                    check_eq("rst_ovalid0", ovalid0, 0);
                    check_eq("rst_done0", done0, 0);
                    check_eq("rst_err0", err0, 0);
                    tick();
                    rst = 1'b0;
                    clear_model();
                    repeat (6) tick();
                    check_eq("rst_no_done", done_seen0 + done_seen2, 0);
                    start = 1'b0;
                    tick();
                    return;
                end
                if (idx == abort_at) begin
                    ivalid = 1'b0;
                    repeat (3) tick();
                    idone    = 1'b1;
                    exp_done = cyc + 1;
                    tick();
                    idone   = 1'b0;
                    aborted = 1'b1;
                end
                if (gapmode == 1 && c == 0 && r > 0) begin
                    ivalid = 1'b0;
                    repeat (4) tick();
                end else if (gapmode == 2 && $urandom_range(0, 3) == 0) begin
                    ivalid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                ivalid = 1'b1;
                din    = img[r][c];
                if (!aborted && r % 2 == 1 && c % 2 == 1) begin
                    q_v0.push_back(pool_ref(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c], 0));
                    q_v2.push_back(pool_ref(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c], 2));
                    q_c0.push_back(cyc + 2);
                    q_c2.push_back(cyc + 2);
                end
                if (!aborted && r == w - 1 && c == w - 1)
                    exp_done = cyc + 3;
                tick();
                idx++;
            end
        end
        ivalid = 1'b0;
        repeat (8) tick();
        check_eq("missing_out0", q_v0.size(), 0);
        check_eq("missing_out2", q_v2.size(), 0);
        check_eq("done0_count", done_seen0, exp_dn);
        check_eq("done2_count", done_seen2, exp_dn);
        start = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        state  = 1'b0;
        ivalid = 1'b0;
        idone  = 1'b0;
        din    = '0;
        repeat (3) tick();
        check_eq("reset_dout0", dout0, 0);
        check_eq("reset_dout2", dout2, 0);
        check_eq("reset_ovalid0", ovalid0, 0);
        check_eq("reset_ovalid2", ovalid2, 0);
        check_eq("reset_done0", done0, 0);
        check_eq("reset_err0", err0, 0);
        rst = 1'b0;
        tick();

        fill_ramp();
        check_eq("model_first_l1", pool_ref(img[0][0], img[0][1], img[1][0], img[1][1], 0), 25);
        run_frame(1'b0, 0, -1, -1);

        fill_const(-5);
        img[1][1] = 1000;
        check_eq("model_first_l2", pool_ref(img[0][0], img[0][1], img[1][0], img[1][1], 2), 250);
        run_frame(1'b1, 0, -1, -1);

        fill_rand(0);
        img[0][0] = -3; img[0][1] = -7; img[1][0] = -1; img[1][1] = -9;
        img[0][2] = -1; img[0][3] = 3;  img[1][2] = -2; img[1][3] = 2;
        run_frame(1'b1, 0, -1, -1);

        fill_ramp();
        run_frame(1'b0, 1, -1, -1);

        for (int k = 0; k < 6; k++) begin
            fill_rand(k % 2);
            run_frame(1'(k % 3 == 0), 2, -1, -1);
        end

        fill_ramp();
        run_frame(1'b0, 0, 100, -1);
        check_eq("err0_set", err0, 1);
        check_eq("err2_set", err2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("err0_cleared", err0, 0);
        check_eq("err2_cleared", err2, 0);

        fill_ramp();
        run_frame(1'b0, 0, -1, 50);
        run_frame(1'b0, 0, -1, -1);
        check_eq("err0_clean", err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
